// File: rtl/usb_tx_sched.sv
// usb_tx_sched: two-requester USB packet transmitter with round-robin arbitration.
// It sends PID, then the payload, then the inverted CRC16 of the payload.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   req[1:0]            per-requester packet request (level, held until done)
//   pid0/pid1           PID nibble per requester
//   len0/len1           payload byte count per requester (clamped to MAX_LEN)
//   pl_data0/pl_data1   first-word-fall-through payload bytes
//   pl_rd[1:0]          one-hot pop strobe to the granted payload source
//   tx_ready            downstream accepts tx_data this cycle
//   tx_valid, tx_data   transmit byte stream
//   gnt[1:0]            one-hot grant, held for the whole packet
//   done[1:0]           one-cycle completion pulse per requester
//   busy                high whenever not idle
module usb_tx_sched #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [3:0]       pid0,
    input  logic [3:0]       pid1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    input  logic [7:0]       pl_data0,
    input  logic [7:0]       pl_data1,
    output logic [1:0]       pl_rd,
    input  logic             tx_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, PID, DATA, CRC_LO, CRC_HI} state_t;

    state_t           state;
    logic [3:0]       pid_q;
    logic [LEN_W-1:0] cnt;
    logic [15:0]      crc;
    logic             last_gnt;   // index of the requester granted most recently
    logic             win;
    logic [LEN_W-1:0] len_sel;
    logic [LEN_W-1:0] len_clamped;
    logic             xfer;

    // Reflected CRC16 (0xA001 form), one byte folded in LSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // On contention the requester not granted last wins; otherwise the lone requester.
    assign win         = (req == 2'b11) ? ~last_gnt : req[1];
    assign len_sel     = win ? len1 : len0;
    assign len_clamped = (len_sel > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_sel;

    assign tx_valid = (state != IDLE);
    assign busy     = (state != IDLE);
    assign xfer     = tx_valid & tx_ready;
    assign pl_rd    = (state == DATA && tx_ready) ? gnt : 2'b00;

    // Payload bytes pass straight through so the FWFT head can be popped in the same cycle;
    // everything else comes from registered state, so it holds steady under backpressure.
    always_comb begin
        tx_data = 8'h00;
        case (state)
            PID:     tx_data = {~pid_q, pid_q};
            DATA:    tx_data = gnt[1] ? pl_data1 : pl_data0;
            CRC_LO:  tx_data = ~crc[7:0];
            CRC_HI:  tx_data = ~crc[15:8];
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            done     <= 2'b00;
            pid_q    <= 4'h0;
            cnt      <= '0;
            crc      <= 16'hFFFF;
            last_gnt <= 1'b1;
        end else begin
            done <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= win ? 2'b10 : 2'b01;
                        last_gnt <= win;
                        pid_q    <= win ? pid1 : pid0;
                        cnt      <= len_clamped;
                        crc      <= 16'hFFFF;
                        state    <= PID;
                    end
                end
                PID: begin
                    if (xfer) state <= (cnt == '0) ? CRC_LO : DATA;
                end
                DATA: begin
                    if (xfer) begin
                        crc <= crc16_byte(crc, tx_data);
                        cnt <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) state <= CRC_LO;
                    end
                end
                CRC_LO: begin
                    if (xfer) state <= CRC_HI;
                end
                CRC_HI: begin
                    if (xfer) begin
                        state <= IDLE;
                        done  <= gnt;
                        gnt   <= 2'b00;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Self-checking bench for usb_tx_sched: directed scenarios plus randomized packets,
// compared cycle by cycle against a packet-level reference model (expected byte queue,
// round-robin winner choice, bit-serial CRC16).
module tb_usb_tx_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [3:0] pid0, pid1;
    logic [6:0] len0, len1;
    logic [7:0] pl_data0, pl_data1;
    logic [1:0] pl_rd;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;

    usb_tx_sched #(.MAX_LEN(64), .LEN_W(7)) dut (
        .clk(clk), .reset(reset), .req(req), .pid0(pid0), .pid1(pid1),
        .len0(len0), .len1(len1), .pl_data0(pl_data0), .pl_data1(pl_data1),
        .pl_rd(pl_rd), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .gnt(gnt), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    // payload sources (FWFT): head is src[r][idx[r]]
    logic [7:0] src [2][256];
    logic [7:0] idx [2];
    assign pl_data0 = src[0][idx[0]];
    assign pl_data1 = src[1][idx[1]];

    int errors = 0;
    int checks = 0;

    // reference model state
    int         cur      = -1;   // requester currently being transmitted
    int         done_who = -1;   // requester whose done pulse is due next cycle
    int         last     = 1;    // last winner; 1 gives requester 0 priority
    int         pos      = 0;    // bytes of current packet already transferred
    int         plen     = 0;    // clamped payload length of current packet
    logic [7:0] exp_q[$];
    logic [3:0] p_pid [2];
    int         p_len [2];
    bit         pend  [2];
    int         rep   [2];
    int         mode  = 0;
    int         cyc   = 0;
    logic [1:0] pop   = 2'b00;
    int         rd_cnt = 0;
    int         gnt_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // bit-serial USB CRC16 over the first n payload bytes of requester w
    function automatic logic [15:0] ref_crc(input int w, input int n);
        logic [15:0] c;
        logic b;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 8; k++) begin
                b = src[w][i][k] ^ c[0];
                c = c >> 1;
                if (b) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    task automatic new_pkt(input int r, input logic [3:0] pid, input int len, input bit incr);
        for (int i = 0; i < 256; i++) src[r][i] = incr ? 8'(i) : 8'($urandom);
        idx[r]   = 8'd0;
        p_pid[r] = pid;
        p_len[r] = len;
        pend[r]  = 1'b1;
    endtask

    // the granted requester scrambles pid/len to show they are ignored after grant
    task automatic drive();
        req  = {pend[1], pend[0]};
        pid0 = (cur == 0) ? 4'($urandom) : p_pid[0];
        len0 = (cur == 0) ? 7'($urandom) : 7'(p_len[0]);
        pid1 = (cur == 1) ? 4'($urandom) : p_pid[1];
        len1 = (cur == 1) ? 7'($urandom) : 7'(p_len[1]);
    endtask

    task automatic model_check();
        logic [31:0] exp_rd;
        logic [15:0] c;
        int w;
        if (exp_q.size() > 0) begin
            chk("tx_valid", 32'(tx_valid), 1);
            chk("busy", 32'(busy), 1);
            chk("gnt", 32'(gnt), 32'(1 << cur));
            chk("tx_data", 32'(tx_data), 32'(exp_q[0]));
            chk("done", 32'(done), 0);
            exp_rd = (pos >= 1 && pos <= plen && tx_ready) ? 32'(1 << cur) : 0;
            chk("pl_rd", 32'(pl_rd), exp_rd);
            if (tx_ready) begin
                void'(exp_q.pop_front());
                pos++;
                if (exp_q.size() == 0) begin
                    done_who = cur;
                    cur = -1;
                end
            end
        end else begin
            chk("idle_valid", 32'(tx_valid), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_gnt", 32'(gnt), 0);
            chk("idle_pl_rd", 32'(pl_rd), 0);
            chk("done", 32'(done), (done_who >= 0) ? 32'(1 << done_who) : 0);
            done_who = -1;
            if (pend[0] && pend[1]) w = 1 - last;
            else if (pend[0])       w = 0;
            else if (pend[1])       w = 1;
            else                    w = -1;
            if (w >= 0) begin
                last = w;
                cur  = w;
                pos  = 0;
                plen = (p_len[w] > 64) ? 64 : p_len[w];
                gnt_log.push_back(w);
                exp_q.push_back({~p_pid[w], p_pid[w]});
                for (int i = 0; i < plen; i++) exp_q.push_back(src[w][i]);
                c = ~ref_crc(w, plen);
                exp_q.push_back(c[7:0]);
                exp_q.push_back(c[15:8]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (pop[0]) idx[0] = idx[0] + 8'd1;
        if (pop[1]) idx[1] = idx[1] + 8'd1;
        if (done_who >= 0) begin
            pend[done_who] = 1'b0;
            if (rep[done_who] > 0) begin
                rep[done_who]--;
                new_pkt(done_who, 4'($urandom), p_len[done_who], 1'b0);
            end
        end
        case (mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom % 10) < 7;
            default: tx_ready = (cyc % 3) == 0;
        endcase
        cyc++;
        drive();
        @(negedge clk);
        model_check();
        pop = pl_rd;
        if (pl_rd != 2'b00) rd_cnt++;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (!(cur < 0 && done_who < 0 && !pend[0] && !pend[1]) && n < budget) begin
            step();
            n++;
        end
        chk("timeout", 32'(n < budget), 1);
    endtask

    // one reset cycle, check the reset state, then release and let arbitration resume
    task automatic do_reset();
        @(posedge clk); #1;
        reset    = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        cur = -1; done_who = -1; last = 1; pos = 0; pop = 2'b00;
        exp_q.delete();
        idx[0] = 8'd0; idx[1] = 8'd0;
        drive();
        @(negedge clk);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pl_rd", 32'(pl_rd), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(tx_data), 0);
        reset = 1'b0;
        model_check();
        pop = pl_rd;
    endtask

    initial begin
        int n;
        reset = 1'b1; req = 2'b00; tx_ready = 1'b0;
        pid0 = 4'h0; pid1 = 4'h0; len0 = 7'd0; len1 = 7'd0;
        idx[0] = 8'd0; idx[1] = 8'd0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; rep[r] = 0; p_pid[r] = 4'h0; p_len[r] = 0;
        end
        repeat (2) @(posedge clk);
        do_reset();

        // zero-length packet: C3 00 00
        mode = 0;
        new_pkt(0, 4'h3, 0, 1'b1);
        run_until_idle(50);

        // four-byte payload 00..03 from requester 1
        new_pkt(1, 4'hB, 4, 1'b1);
        rd_cnt = 0;
        run_until_idle(50);
        chk("rd_cnt_payload", 32'(rd_cnt), 4);

        // same packet under a 1,0,0 ready pattern
        mode = 2;
        new_pkt(1, 4'hB, 4, 1'b1);
        rd_cnt = 0;
        run_until_idle(100);
        chk("rd_cnt_stall", 32'(rd_cnt), 4);

        // contention: both held, each re-requests once; grants alternate from 0
        mode = 0;
        new_pkt(0, 4'h5, 1, 1'b0);
        new_pkt(1, 4'h6, 1, 1'b0);
        rep[0] = 1; rep[1] = 1;
        gnt_log.delete();
        do_reset();
        run_until_idle(100);
        chk("rr_count", 32'(gnt_log.size()), 4);
        if (gnt_log.size() == 4)
            for (int i = 0; i < 4; i++) chk("rr_order", 32'(gnt_log[i]), 32'(i % 2));

        // oversize length is clamped to 64 payload bytes
        mode = 1;
        new_pkt(0, 4'h7, 100, 1'b0);
        rd_cnt = 0;
        run_until_idle(400);
        chk("clamp_rd", 32'(rd_cnt), 64);

        // reset mid-payload aborts the packet; held request is re-granted afresh
        mode = 0;
        new_pkt(0, 4'h9, 20, 1'b0);
        n = 0;
        while (!(cur == 0 && pos == 10) && n < 40) begin
            step();
            n++;
        end
        chk("abort_reach", 32'(cur == 0 && pos == 10), 1);
        do_reset();
        run_until_idle(100);

        // randomized packets, lengths and backpressure
        for (int it = 0; it < 40; it++) begin
            mode = $urandom % 2;
            for (int r = 0; r < 2; r++)
                if ($urandom % 2) begin
                    new_pkt(r, 4'($urandom), $urandom_range(0, 80), 1'b0);
                    rep[r] = $urandom % 3;
                end
            if (!pend[0] && !pend[1]) new_pkt(0, 4'($urandom), $urandom_range(0, 80), 1'b0);
            run_until_idle(2000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
